hex_count_ctrl: RTL and testbench

- Sequential counter stage that sits directly upstream of the hex 7-segment decoder.
- Replaces raw switch drive of the 4-bit display value with a debounced, button-driven counter.
- Supports single step, free-run at a prescaled rate, up/down direction and parallel load from switches.
- count[3:0] connects straight to the decoder's 4-bit input. wrap and running drive LEDs.

---
 rtl/hex_count_ctrl.sv | 148 ++++++++++++++
 tb/tb_hex_count_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_count_ctrl.sv
// Debounced button-driven 4-bit counter (step / free-run / load) feeding the hex 7-seg decoder.
// Optional build macro HEX_COUNT_BCD_MODE_EN restricts the count to 0..9 and saturates loads at 9.

module hex_count_deb #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [DW-1:0] cnt;
  logic          level, level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      if (sync[1] == level)
        cnt <= '0;
      else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  // One pulse per accepted press; releases are silent.
  assign press = level & ~level_q;
endmodule

module hex_count_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic       btn_run,
  input  logic       btn_load,
  input  logic       sw_up,
  input  logic [3:0] sw_val,
  output logic [3:0] count,
  output logic       wrap,
  output logic       running
);
  localparam int NBTN   = 3;
  localparam int B_STEP = 0;
  localparam int B_RUN  = 1;
  localparam int B_LOAD = 2;
  localparam int PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
`ifdef HEX_COUNT_BCD_MODE_EN
  localparam logic [3:0] CMAX = 4'd9;
`else
  localparam logic [3:0] CMAX = 4'd15;
`endif

  typedef enum logic {STOP, RUN} state_t;

  logic [NBTN-1:0]  btn_raw, btn_press;
  logic [1:0][4:0]  sw_sync;
  logic             up;
  logic [3:0]       val, load_val;
  logic [4:0]       nxt;
  logic [PW-1:0]    presc;
  state_t           state;

  assign btn_raw = {btn_load, btn_run, btn_step};

  hex_count_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NBTN-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_raw),
    .press (btn_press)
  );

  // Switches are synchronized only; bounce on them is harmless.
  always_ff @(posedge clk) begin
    if (!rst_n) sw_sync <= '0;
    else        sw_sync <= {sw_sync[0], {sw_up, sw_val}};
  end

  assign up  = sw_sync[1][4];
  assign val = sw_sync[1][3:0];

`ifdef HEX_COUNT_BCD_MODE_EN
  assign load_val = (val > CMAX) ? CMAX : val;
`else
  assign load_val = val;
`endif

  function automatic logic [4:0] stepv(input logic [3:0] c, input logic u);
    if (u) return (c == CMAX) ? {1'b1, 4'd0} : {1'b0, c + 4'd1};
    else   return (c == 4'd0) ? {1'b1, CMAX} : {1'b0, c - 4'd1};
  endfunction

  assign nxt = stepv(count, up);

  // Priority: load > run toggle > step/tick; a tick landing with a toggle or load is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= STOP;
      count   <= 4'd0;
      wrap    <= 1'b0;
      running <= 1'b0;
      presc   <= '0;
    end else begin
      wrap <= 1'b0;
      if (btn_press[B_LOAD]) begin
        count <= load_val;
        presc <= '0;
      end
      if (btn_press[B_RUN]) begin
        presc <= '0;
        if (state == STOP) begin
          state   <= RUN;
          running <= 1'b1;
        end else begin
          state   <= STOP;
          running <= 1'b0;
        end
      end else if (!btn_press[B_LOAD]) begin
        case (state)
          STOP: if (btn_press[B_STEP]) {wrap, count} <= nxt;
          RUN: begin
            if (presc == PLAST) begin
              presc         <= '0;
              {wrap, count} <= nxt;
            end else
              presc <= presc + 1'b1;
          end
          default: state <= STOP;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hex_count_ctrl.sv
// Randomized scoreboard bench for hex_count_ctrl: an event-level model predicts every visible
// change of count/running (with its cycle) and a negedge monitor compares what the DUT shows.

module tb_hex_count_ctrl;
  localparam int DEB  = 4;
  localparam int TDIV = 8;
`ifdef HEX_COUNT_BCD_MODE_EN
  localparam int MOD = 10;
`else
  localparam int MOD = 16;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       btn_step = 1'b0, btn_run = 1'b0, btn_load = 1'b0, sw_up = 1'b0;
  logic [3:0] sw_val = 4'd0;
  logic [3:0] count;
  logic       wrap, running;

  hex_count_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_run(btn_run), .btn_load(btn_load),
    .sw_up(sw_up), .sw_val(sw_val), .count(count), .wrap(wrap), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Expected visible change: at edge t, outputs become (c, w, r).
  typedef struct {
    int         t;
    logic [3:0] c;
    logic       w;
    logic       r;
  } exp_t;
  exp_t q[$];

  int m_cnt = 0;
  bit m_run = 0;
  int next_tick = 0;
  bit up_old = 0, up_new = 0;
  int up_t = 0;

  function automatic bit dir_at(input int t);
    return (t >= up_t + 3) ? up_new : up_old;
  endfunction

  task automatic push(input int t, input bit w);
    exp_t e;
    e.t = t; e.c = 4'(m_cnt); e.w = w; e.r = m_run;
    q.push_back(e);
  endtask

  task automatic do_step(input int t);
    bit w;
    if (dir_at(t)) begin
      w = (m_cnt == MOD - 1);
      m_cnt = (m_cnt + 1) % MOD;
    end else begin
      w = (m_cnt == 0);
      m_cnt = (m_cnt + MOD - 1) % MOD;
    end
    push(t, w);
  endtask

  task automatic advance(input int upto);
    while (m_run && next_tick < upto) begin
      do_step(next_tick);
      next_tick += TDIV;
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      advance(cyc + 2);
    end
  endtask

  task automatic press_model(input bit s, input bit r, input bit l, input int v, input int t);
    bit changed = 0;
    int nv;
    advance(t);
    if (l) begin
      nv = (v > MOD - 1) ? MOD - 1 : v;
      if (nv != m_cnt) changed = 1;
      m_cnt = nv;
      next_tick = t + TDIV;
    end
    if (r) begin
      m_run = !m_run;
      next_tick = t + TDIV;
      changed = 1;
    end
    if (l || r) begin
      if (changed) push(t, 1'b0);
    end else if (s && !m_run)
      do_step(t);
  endtask

  task automatic op(input bit s, input bit r, input bit l, input bit up, input int v, input int hold);
    int c;
    if (up != up_new) begin
      up_old = up_new; up_new = up; up_t = cyc;
    end
    sw_up = up; sw_val = 4'(v);
    tick_wait(4);
    c = cyc;
    btn_step = s; btn_run = r; btn_load = l;
    if (hold >= DEB) press_model(s, r, l, v, c + DEB + 3);
    tick_wait(hold);
    btn_step = 0; btn_run = 0; btn_load = 0;
    tick_wait(2 * DEB + 8);
  endtask

  task automatic bounce();
    int pat [4] = '{1, 0, 1, 0};
    foreach (pat[i]) begin
      btn_step = pat[i][0];
      tick_wait(1);
    end
    btn_step = 0;
    tick_wait(2 * DEB + 8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    if (m_cnt != 0 || m_run) begin
      m_cnt = 0; m_run = 0;
      push(cyc + 1, 1'b0);
    end
    m_cnt = 0; m_run = 0;
    tick_wait(2);
    rst_n = 1;
  endtask

  bit         mon_en = 0;
  logic [3:0] pc = 4'd0;
  logic       pr = 1'b0;
  exp_t       me;

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].t < cyc) begin
        me = q.pop_front();
        chk("missed_event_cycle", cyc, me.t);
      end
      if (count !== pc || running !== pr) begin
        if (q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          me = q.pop_front();
          chk("event_cycle", cyc, me.t);
          chk("count", int'(count), int'(me.c));
          chk("wrap", int'(wrap), int'(me.w));
          chk("running", int'(running), int'(me.r));
        end
      end else
        chk("wrap_idle", int'(wrap), 0);
      pc = count;
      pr = running;
    end
  end

  initial begin
    int kind;
    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_running", int'(running), 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_count", int'(count), 0);
    mon_en = 1;

    op(1, 0, 0, 1, 0, 10);          // long step press: exactly one step, DEB+3 latency
    bounce();                       // 1,0,1,0 glitch rejected
    op(1, 0, 0, 1, 0, DEB - 1);     // one cycle short of acceptance
    op(1, 0, 0, 1, 0, DEB);         // shortest accepted press
    op(0, 0, 1, 1, 15, DEB + 1);    // load 15 (9 in decimal build)
    op(1, 0, 0, 1, 0, DEB);         // up-wrap
    op(1, 0, 0, 0, 0, DEB);         // down-wrap
    op(0, 0, 1, 1, 3, DEB);
    op(0, 1, 0, 1, 3, DEB);         // enter RUN
    tick_wait(20);
    op(1, 0, 0, 1, 3, DEB);         // step ignored in RUN
    op(0, 1, 0, 1, 3, DEB);         // back to STOP
    op(0, 1, 1, 1, 10, DEB + 2);    // load + run together
    tick_wait(12);
    op(0, 1, 0, 1, 10, DEB);
    op(0, 0, 1, 1, 12, DEB);        // out-of-range in decimal build

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        1:       op(0, 1, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(DEB, DEB + 5));
        2:       op(0, 0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(DEB, DEB + 5));
        3:       op(0, 1, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(DEB, DEB + 5));
        4:       bounce();
        default: op(1, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(DEB - 1, DEB + 5));
      endcase
      tick_wait($urandom_range(0, 20));
    end

    if (m_run) op(0, 1, 0, up_new, 0, DEB);
    for (int i = 0; i < 200 && q.size() > 0; i++) tick_wait(1);
    chk("queue_drained", q.size(), 0);

    op(0, 1, 0, 1, 0, DEB);         // RUN again, then reset mid-run
    tick_wait(19);
    do_reset();
    tick_wait(3);
    chk("mid_run_rst_count", int'(count), 0);
    chk("mid_run_rst_running", int'(running), 0);
    for (int i = 0; i < 50 && q.size() > 0; i++) tick_wait(1);
    chk("queue_drained_final", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
